id_scoreboard_stage: RTL and testbench
======================================

Name: id_scoreboard_stage

Overview:
- Parametrised successor to the combinational decode stage.
- Decodes the logic-immediate and logic-register MIPS subset and reads the register file.
- Tracks in-flight destination registers in a DEPTH-entry scoreboard shift register. The previous design compared against two hard-wired registers; this block generalises that to DEPTH entries.
- Stalls fetch and inserts bubbles on RAW hazards. Registers the decoded operands into the ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage.

Parameters:
- DATA_W, 32, register/immediate data width.
- ADDR_W, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 2, cycles from issue until the write is visible to a same-cycle regfile read. Legal range is 1 to 8.
- OP_W, 8, aluop width.
- SEL_W, 3, alusel width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_valid_i  in  1  IF/ID holds a valid instruction.
- pc_i  in  32  PC of the instruction.
- inst_i  in  32  instruction word.
- flush_i  in  1  kill the current decode and the ID/EX register contents.
- reg1_data_i  in  DATA_W  regfile port 1 read data (combinational).
- reg2_data_i  in  DATA_W  regfile port 2 read data (combinational).
- reg1_read_o  out  1  port 1 read enable (combinational).
- reg2_read_o  out  1  port 2 read enable (combinational).
- reg1_addr_o  out  ADDR_W  port 1 address, inst[25:21] (combinational).
- reg2_addr_o  out  ADDR_W  port 2 address, inst[20:16] (combinational).
- stall_o  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid_o  out  1  ID/EX register holds an issued instruction.
- pc_o  out  32  PC of the issued instruction.
- aluop_o  out  OP_W  issued aluop.
- alusel_o  out  SEL_W  issued alusel.
- reg1_o  out  DATA_W  issued operand 1.
- reg2_o  out  DATA_W  issued operand 2.
- wd_o  out  ADDR_W  issued destination register.
- wreg_o  out  1  issued instruction writes a register.
- inst_invalid_o  out  1  issued slot carried an undecodable opcode.

Behaviour:
- Decode:
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: read rs only; imm = zero-extended inst[15:0]; wd = inst[20:16].
  - LUI 0x0F: no reads; imm = {inst[15:0], 16'h0}; aluop OR; operand 1 = 0; wd = inst[20:16].
  - SPECIAL op 0x00 with shamt 0: funct 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR. Read rs and rt; wd = inst[15:11].
  - Any other encoding decodes as NOP with wreg = 0 and invalid = 1. It is still issued and carries inst_invalid_o.
  - The all-zero word decodes as NOP with invalid = 0.
- Operand select:
  - Operand n = regn_data_i when regn_read is high, else imm.
  - A read of register 0 yields 0 regardless of regfile data.
- Scoreboard:
  - DEPTH entries of {v, addr}; entry 0 is the youngest.
  - Every cycle the entries shift by one and the oldest is dropped.
  - Entry 0 loads {1, wd} when an instruction issues with wreg = 1 and wd != 0. Otherwise entry 0 loads {0, 0}, i.e. a bubble.
- Hazard and stall:
  - hazard = (reg1_read and rs != 0 and rs matches any valid entry) or (reg2_read and rt != 0 and rt matches any valid entry).
  - stall_o = inst_valid_i and hazard and not flush_i.
- Issue:
  - Issue = inst_valid_i and not stall_o and not flush_i.
  - On issue, the ID/EX register loads the decoded fields and ex_valid_o = 1.
  - Otherwise the ID/EX register loads a bubble: ex_valid_o = 0, wreg_o = 0, aluop and alusel NOP, data 0, wd 0, inst_invalid_o = 0.
- Latency:
  - One cycle from issue to the ID/EX outputs.
  - Dependent back-to-back instructions stall exactly DEPTH cycles, then issue on the following cycle.
- Flush:
  - Forces a bubble into ID/EX this edge and clears all scoreboard valid bits.
  - flush_i overrides stall_o.
- Reset (async, rst = 0):
  - All ID/EX outputs and scoreboard entries go to 0 immediately.
  - Combinational outputs follow the inputs.
  - Reset mid-stall discards the pending hazard; after release the held instruction issues with no stall.

Test Plan:
- ORI $1,$0,0x1234 then ANDI $2,$3,0x00FF with no dependence -> both issue on consecutive cycles. ex outputs: wd=1, reg1_o=0, reg2_o=0x1234, then wd=2, reg2_o=0xFF. stall_o never asserts.
- ORI $1,$0,5 then XORI $4,$1,3 with DEPTH=2 -> stall_o high for 2 cycles and two bubbles in ID/EX (ex_valid_o=0). XORI issues in the 3rd cycle with reg1_o equal to regfile $1.
- Rebuild with DEPTH=4 and repeat the previous case -> exactly 4 stall cycles. An independent instruction placed between them reduces the stall to 3.
- ORI $0,$0,7 then OR $5,$0,$0 -> no stall, since register 0 is never tracked; reg1_o=reg2_o=0 even when the regfile drives 0xDEADBEEF.
- Stalled XORI with flush_i=1 -> bubble issued, scoreboard cleared. The next cycle XORI $4,$1,3 issues without a stall.
- Opcode 0x3F issued -> ex_valid_o=1, inst_invalid_o=1, wreg_o=0. Asserting rst low mid-stall -> all ex outputs 0 asynchronously, and the instruction issues on the first edge after release.

Source files
------------

// File: rtl/id_scoreboard_stage.sv
// Decode stage for the MIPS logic subset with a DEPTH-entry RAW scoreboard.
// Stalls fetch on hazards and registers decoded operands into ID/EX.
module id_scoreboard_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [ADDR_W-1:0] reg1_addr_o,
  output logic [ADDR_W-1:0] reg2_addr_o,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [31:0]       pc_o,
  output logic [OP_W-1:0]   aluop_o,
  output logic [SEL_W-1:0]  alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic              inst_invalid_o
);

  localparam logic [OP_W-1:0]  OP_NOP    = '0;
  localparam logic [OP_W-1:0]  OP_AND    = OP_W'(8'h24);
  localparam logic [OP_W-1:0]  OP_OR     = OP_W'(8'h25);
  localparam logic [OP_W-1:0]  OP_XOR    = OP_W'(8'h26);
  localparam logic [OP_W-1:0]  OP_NOR    = OP_W'(8'h27);
  localparam logic [SEL_W-1:0] SEL_NOP   = '0;
  localparam logic [SEL_W-1:0] SEL_LOGIC = SEL_W'(1);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;

  assign opcode = inst_i[31:26];
  assign funct  = inst_i[5:0];
  assign shamt  = inst_i[10:6];
  assign rs     = ADDR_W'(inst_i[25:21]);
  assign rt     = ADDR_W'(inst_i[20:16]);
  assign rd     = ADDR_W'(inst_i[15:11]);

  logic              dec_rd1;
  logic              dec_rd2;
  logic [OP_W-1:0]   dec_op;
  logic [SEL_W-1:0]  dec_sel;
  logic [ADDR_W-1:0] dec_wd;
  logic              dec_wreg;
  logic              dec_inv;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_rd1  = 1'b0;
    dec_rd2  = 1'b0;
    dec_op   = OP_NOP;
    dec_sel  = SEL_NOP;
    dec_wd   = '0;
    dec_wreg = 1'b0;
    dec_inv  = 1'b0;
    dec_imm  = '0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: begin
        dec_rd1  = 1'b1;
        dec_imm  = DATA_W'(inst_i[15:0]);
        dec_wd   = rt;
        dec_wreg = 1'b1;
        dec_sel  = SEL_LOGIC;
        dec_op   = (opcode == 6'h0C) ? OP_AND :
                   (opcode == 6'h0D) ? OP_OR  : OP_XOR;
      end
      6'h0F: begin
        dec_imm  = DATA_W'({inst_i[15:0], 16'h0000});
        dec_wd   = rt;
        dec_wreg = 1'b1;
        dec_sel  = SEL_LOGIC;
        dec_op   = OP_OR;
      end
      6'h00: begin
        // the all-zero word is the canonical NOP, not an illegal encoding
        if (inst_i != 32'h0) begin
          if (shamt == 5'h0 && funct inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
            dec_rd1  = 1'b1;
            dec_rd2  = 1'b1;
            dec_wd   = rd;
            dec_wreg = 1'b1;
            dec_sel  = SEL_LOGIC;
            case (funct)
              6'h24:   dec_op = OP_AND;
              6'h25:   dec_op = OP_OR;
              6'h26:   dec_op = OP_XOR;
              default: dec_op = OP_NOR;
            endcase
          end else begin
            dec_inv = 1'b1;
          end
        end
      end
      default: dec_inv = 1'b1;
    endcase
  end

  // Operand 1 is never an immediate: LUI places its constant on operand 2.
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign op1 = !dec_rd1 ? '0 : (rs == '0) ? '0 : reg1_data_i;
  assign op2 = !dec_rd2 ? dec_imm : (rt == '0) ? '0 : reg2_data_i;

  logic              sb_v [DEPTH];
  logic [ADDR_W-1:0] sb_a [DEPTH];
  logic              hit1;
  logic              hit2;
  logic              hazard;
  logic              issue;
  logic              push;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v[i] && sb_a[i] == rs) hit1 = 1'b1;
      if (sb_v[i] && sb_a[i] == rt) hit2 = 1'b1;
    end
  end

  assign hazard = (dec_rd1 && rs != '0 && hit1) || (dec_rd2 && rt != '0 && hit2);
  assign stall_o = inst_valid_i && hazard && !flush_i;
  assign issue   = inst_valid_i && !hazard && !flush_i;
  assign push    = issue && dec_wreg && (dec_wd != '0);

  assign reg1_read_o = dec_rd1;
  assign reg2_read_o = dec_rd2;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_v[i] <= 1'b0;
        sb_a[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_v[i] <= 1'b0;
        sb_a[i] <= '0;
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_v[i] <= sb_v[i-1];
        sb_a[i] <= sb_a[i-1];
      end
      sb_v[0] <= push;
      sb_a[0] <= push ? dec_wd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o     <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= OP_NOP;
      alusel_o       <= SEL_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (issue) begin
      ex_valid_o     <= 1'b1;
      pc_o           <= pc_i;
      aluop_o        <= dec_op;
      alusel_o       <= dec_sel;
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      inst_invalid_o <= dec_inv;
    end else begin
      ex_valid_o     <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= OP_NOP;
      alusel_o       <= SEL_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Bench for id_scoreboard_stage: two instances (DEPTH 2 and 4) share stimulus
// and are checked against a cycle-stamp hazard model plus fixed vectors.
module tb_id_scoreboard_stage;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        flush;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic [31:0] regs [32];

  logic        rd1   [2];
  logic        rd2   [2];
  logic [4:0]  a1    [2];
  logic [4:0]  a2    [2];
  logic        stall [2];
  logic        ex_valid [2];
  logic [31:0] pc_q  [2];
  logic [7:0]  aluop [2];
  logic [2:0]  alusel[2];
  logic [31:0] r1    [2];
  logic [31:0] r2    [2];
  logic [4:0]  wd_q  [2];
  logic        wreg_q[2];
  logic        inv   [2];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int last_iss [2][32];

  assign rd1_data = regs[inst[25:21]];
  assign rd2_data = regs[inst[20:16]];

  id_scoreboard_stage #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
    .flush_i(flush), .reg1_data_i(rd1_data), .reg2_data_i(rd2_data),
    .reg1_read_o(rd1[0]), .reg2_read_o(rd2[0]), .reg1_addr_o(a1[0]), .reg2_addr_o(a2[0]),
    .stall_o(stall[0]), .ex_valid_o(ex_valid[0]), .pc_o(pc_q[0]), .aluop_o(aluop[0]),
    .alusel_o(alusel[0]), .reg1_o(r1[0]), .reg2_o(r2[0]), .wd_o(wd_q[0]),
    .wreg_o(wreg_q[0]), .inst_invalid_o(inv[0]));

  id_scoreboard_stage #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
    .flush_i(flush), .reg1_data_i(rd1_data), .reg2_data_i(rd2_data),
    .reg1_read_o(rd1[1]), .reg2_read_o(rd2[1]), .reg1_addr_o(a1[1]), .reg2_addr_o(a2[1]),
    .stall_o(stall[1]), .ex_valid_o(ex_valid[1]), .pc_o(pc_q[1]), .aluop_o(aluop[1]),
    .alusel_o(alusel[1]), .reg1_o(r1[1]), .reg2_o(r2[1]), .wd_o(wd_q[1]),
    .wreg_o(wreg_q[1]), .inst_invalid_o(inv[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd1;
    logic        rd2;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [4:0]  wd;
    logic        wreg;
    logic        inv;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] w;
    logic        r1e;
    logic        r2e;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  wd;
    logic        wreg;
    logic        inv;
  } vec_t;

  vec_t tv [14];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference decode derived from the opcode table with arithmetic mapping.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc;
    logic [5:0] fn;
    d   = '0;
    opc = w[31:26];
    fn  = w[5:0];
    if (opc >= 6'h0C && opc <= 6'h0E) begin
      d.rd1 = 1'b1; d.imm = {16'h0, w[15:0]}; d.wd = w[20:16]; d.wreg = 1'b1;
      d.sel = 3'd1; d.op = 8'h24 + 8'(opc - 6'h0C);
    end else if (opc == 6'h0F) begin
      d.imm = {w[15:0], 16'h0}; d.wd = w[20:16]; d.wreg = 1'b1; d.sel = 3'd1; d.op = 8'h25;
    end else if (w == 32'h0) begin
      d = '0;
    end else if (opc == 6'h00 && w[10:6] == 5'h0 && fn >= 6'h24 && fn <= 6'h27) begin
      d.rd1 = 1'b1; d.rd2 = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.sel = 3'd1;
      d.op = {2'b00, fn};
    end else begin
      d.inv = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rval(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : regs[a];
  endfunction

  // A register is busy while fewer than DEPTH+1 cycles have passed since its issue.
  function automatic logic model_hz(input int k, input logic [31:0] w, input dec_t d);
    logic b1;
    logic b2;
    b1 = d.rd1 && w[25:21] != 5'd0 && (cyc_n - last_iss[k][w[25:21]] <= dep(k));
    b2 = d.rd2 && w[20:16] != 5'd0 && (cyc_n - last_iss[k][w[20:16]] <= dep(k));
    return b1 || b2;
  endfunction

  task automatic model_clear(input int k);
    for (int r = 0; r < 32; r++) last_iss[k][r] = -1000;
  endtask

  function automatic logic [114:0] ex_pack(input int k);
    return {ex_valid[k], wreg_q[k], inv[k], wd_q[k], alusel[k], aluop[k], pc_q[k], r1[k], r2[k]};
  endfunction

  task automatic step(input logic [31:0] w, input logic v, input logic f,
                      output logic s0, output logic s1);
    dec_t         d;
    logic [114:0] e [2];
    logic         iss [2];
    logic         hz;
    inst = w; inst_valid = v; flush = f; pc = $urandom;
    d = ref_dec(w);
    @(negedge clk);
    chk("read_ports", 128'({rd1[0], rd2[0], a1[0], a2[0]}),
        128'({d.rd1, d.rd2, w[25:21], w[20:16]}));
    for (int k = 0; k < 2; k++) begin
      hz = model_hz(k, w, d);
      chk($sformatf("stall_d%0d", dep(k)), 128'(stall[k]), 128'(v && hz && !f));
      iss[k] = v && !hz && !f;
      e[k] = iss[k] ? {1'b1, d.wreg, d.inv, d.wd, d.sel, d.op, pc,
                       d.rd1 ? rval(w[25:21]) : 32'h0,
                       d.rd2 ? rval(w[20:16]) : d.imm} : 115'h0;
    end
    s0 = stall[0];
    s1 = stall[1];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ex_d%0d", dep(k)), 128'(ex_pack(k)), 128'(e[k]));
      if (f) model_clear(k);
      else if (iss[k] && d.wreg && d.wd != 5'd0) last_iss[k][d.wd] = cyc_n;
    end
    cyc_n++;
  endtask

  // Presents one instruction until both instances have issued it.
  task automatic hold(input logic [31:0] w, output int n0, output int n1,
                      output logic [31:0] o0, output logic [31:0] o1);
    logic done0;
    logic done1;
    logic s0;
    logic s1;
    done0 = 1'b0; done1 = 1'b0; n0 = 0; n1 = 0; o0 = 32'h0; o1 = 32'h0;
    for (int n = 0; n < 12 && !(done0 && done1); n++) begin
      step(w, 1'b1, 1'b0, s0, s1);
      if (!done0) begin
        if (s0) n0++;
        else begin done0 = 1'b1; o0 = r1[0]; end
      end
      if (!done1) begin
        if (s1) n1++;
        else begin done1 = 1'b1; o1 = r1[1]; end
      end
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1, 2: return {6'($urandom_range(12, 15)), a, b, 16'($urandom)};
      3, 4, 5: return {6'h00, a, b, c, 5'h0, 6'($urandom_range(36, 39))};
      6:       return ($urandom_range(0, 1) == 0) ? 32'h0 : {6'h00, a, b, c, 5'h3, 6'h25};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s0;
    logic        s1;
    int          n0;
    int          n1;
    logic [31:0] o0;
    logic [31:0] o1;

    tv[0]  = '{32'h34011234, 1'b1, 1'b0, 8'h25, 3'd1, 32'h0,        32'h1234,     5'd1,  1'b1, 1'b0};
    tv[1]  = '{32'h306200FF, 1'b1, 1'b0, 8'h24, 3'd1, 32'h03030303, 32'h000000FF, 5'd2,  1'b1, 1'b0};
    tv[2]  = '{32'h38240003, 1'b1, 1'b0, 8'h26, 3'd1, 32'h01010101, 32'h3,        5'd4,  1'b1, 1'b0};
    tv[3]  = '{32'h38A78000, 1'b1, 1'b0, 8'h26, 3'd1, 32'h05050505, 32'h8000,     5'd7,  1'b1, 1'b0};
    tv[4]  = '{32'h3D26ABCD, 1'b0, 1'b0, 8'h25, 3'd1, 32'h0,        32'hABCD0000, 5'd6,  1'b1, 1'b0};
    tv[5]  = '{32'h012A4024, 1'b1, 1'b1, 8'h24, 3'd1, 32'h09090909, 32'h0A0A0A0A, 5'd8,  1'b1, 1'b0};
    tv[6]  = '{32'h00002825, 1'b1, 1'b1, 8'h25, 3'd1, 32'h0,        32'h0,        5'd5,  1'b1, 1'b0};
    tv[7]  = '{32'h018D5826, 1'b1, 1'b1, 8'h26, 3'd1, 32'h0C0C0C0C, 32'h0D0D0D0D, 5'd11, 1'b1, 1'b0};
    tv[8]  = '{32'h03DDF827, 1'b1, 1'b1, 8'h27, 3'd1, 32'h1E1E1E1E, 32'h1D1D1D1D, 5'd31, 1'b1, 1'b0};
    tv[9]  = '{32'hFC221234, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    tv[10] = '{32'h00000000, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0};
    tv[11] = '{32'h012A4064, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    tv[12] = '{32'h012A4020, 1'b0, 1'b0, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    tv[13] = '{32'h34000007, 1'b1, 1'b0, 8'h25, 3'd1, 32'h0,        32'h7,        5'd0,  1'b1, 1'b0};

    regs[0] = 32'hDEADBEEF;
    for (int r = 1; r < 32; r++) regs[r] = 32'h01010101 * r;
    inst = 32'h0; inst_valid = 1'b0; flush = 1'b0; pc = 32'h0;
    model_clear(0);
    model_clear(1);

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ex", 128'(ex_pack(k)), 128'h0);
      chk("reset_stall", 128'(stall[k]), 128'h0);
    end
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    // fixed decode vectors, each preceded by a flush to empty the scoreboard
    for (int i = 0; i < 14; i++) begin
      step(32'h0, 1'b0, 1'b1, s0, s1);
      step(tv[i].w, 1'b1, 1'b0, s0, s1);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_d%0d", i, dep(k)),
            128'({ex_valid[k], wreg_q[k], inv[k], wd_q[k], alusel[k], aluop[k], r1[k], r2[k], rd1[k], rd2[k]}),
            128'({1'b1, tv[i].wreg, tv[i].inv, tv[i].wd, tv[i].sel, tv[i].op, tv[i].o1, tv[i].o2, tv[i].r1e, tv[i].r2e}));
      end
    end

    // independent back-to-back
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34011234, 1'b1, 1'b0, s0, s1);
    chk("indep1_stall", 128'({s0, s1}), 128'h0);
    chk("indep1_ex", 128'({ex_valid[0], wd_q[0], r1[0], r2[0]}), 128'({1'b1, 5'd1, 32'h0, 32'h1234}));
    step(32'h306200FF, 1'b1, 1'b0, s0, s1);
    chk("indep2_stall", 128'({s0, s1}), 128'h0);
    chk("indep2_ex", 128'({ex_valid[0], wd_q[0], r2[0]}), 128'({1'b1, 5'd2, 32'hFF}));

    // dependent pair: stall length equals DEPTH
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34010005, 1'b1, 1'b0, s0, s1);
    hold(32'h38240003, n0, n1, o0, o1);
    chk("dep_stall_d2", 128'(n0), 128'd2);
    chk("dep_stall_d4", 128'(n1), 128'd4);
    chk("dep_op1", 128'({o0, o1}), 128'({32'h01010101, 32'h01010101}));

    // one independent instruction in between shortens the stall by one
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34010005, 1'b1, 1'b0, s0, s1);
    step(32'h306200FF, 1'b1, 1'b0, s0, s1);
    hold(32'h38240003, n0, n1, o0, o1);
    chk("gap_stall_d2", 128'(n0), 128'd1);
    chk("gap_stall_d4", 128'(n1), 128'd3);

    // register 0 is never tracked and always reads zero
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34000007, 1'b1, 1'b0, s0, s1);
    step(32'h00002825, 1'b1, 1'b0, s0, s1);
    chk("r0_stall", 128'({s0, s1}), 128'h0);
    chk("r0_ops", 128'({ex_valid[1], r1[1], r2[1]}), 128'({1'b1, 32'h0, 32'h0}));

    // flush of a stalled instruction clears the scoreboard
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34010005, 1'b1, 1'b0, s0, s1);
    step(32'h38240003, 1'b1, 1'b0, s0, s1);
    chk("fl_pre_stall", 128'({s0, s1}), 128'h3);
    step(32'h38240003, 1'b1, 1'b1, s0, s1);
    chk("fl_override", 128'({s0, s1, ex_valid[0], ex_valid[1]}), 128'h0);
    step(32'h38240003, 1'b1, 1'b0, s0, s1);
    chk("fl_post", 128'({s0, s1, ex_valid[0], ex_valid[1], wd_q[0], wd_q[1]}),
        128'({4'b0011, 5'd4, 5'd4}));

    // asynchronous reset in the middle of a stall
    step(32'h0, 1'b0, 1'b1, s0, s1);
    step(32'h34010005, 1'b1, 1'b0, s0, s1);
    chk("rst_pre_valid", 128'({ex_valid[0], ex_valid[1]}), 128'h3);
    inst = 32'h38240003; inst_valid = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk("rst_pre_stall", 128'({stall[0], stall[1]}), 128'h3);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_async_ex_d%0d", dep(k)), 128'(ex_pack(k)), 128'h0);
      chk($sformatf("rst_stall_d%0d", dep(k)), 128'(stall[k]), 128'h0);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("rst_issue_d%0d", dep(k)), 128'({ex_valid[k], wd_q[k], r1[k]}),
          128'({1'b1, 5'd4, 32'h01010101}));
    model_clear(0);
    model_clear(1);
    step(32'h0, 1'b0, 1'b1, s0, s1);

    // randomized traffic against the cycle-stamp model
    for (int r = 1; r < 32; r++) regs[r] = $urandom;
    for (int n = 0; n < 400; n++) begin
      regs[$urandom_range(1, 31)] = $urandom;
      step(rnd_inst(), $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, s0, s1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
